// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, lane constants and index-width helper for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: req/ack data-memory bus between the CPU memory stage and the responder
interface dmem_responder_if #(parameter int AW = 32);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          ack;
    logic [31:0]   rdata;
    logic          err;
    logic          busy;
    modport master (output req, we, addr, wdata, be, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage, synchronous byte-enabled write, asynchronous read, no reset
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                   clk_i,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [log2(DEPTH)-1:0] windex,
    input  logic [31:0]            wdata,
    input  logic [log2(DEPTH)-1:0] rindex,
    output logic [31:0]            rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk_i)
        for (int b = 0; b < LANES; b++)
            if (we && be[b]) mem[windex][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
    assign rdata = mem[rindex];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory target with programmable wait states,
// byte-enabled stores and misaligned/out-of-range error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    dmem_responder_if.slave bus
);
    localparam int IW = log2(DEPTH);
    localparam logic [3:0] LAT_M1 = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two >= 4");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be 0..15");
    end
    state_t         state;
    logic [3:0]     cnt;
    logic           cap_we, cap_err;
    logic [IW-1:0]  cap_idx;
    logic [31:0]    cap_wdata;
    logic [3:0]     cap_be;
    logic           ack_q, err_q;
    logic [31:0]    rdata_q;
    logic           in_err, n_we, n_err, arr_we;
    logic [IW-1:0]  n_idx;
    logic [31:0]    arr_rdata, resp_rdata;
    // Upper address bits beyond the array must be zero: no aliasing of out-of-range words.
    assign in_err = (bus.addr[1:0] != 2'b00) || (|bus.addr[AW-1:IW+2]);
    // With LATENCY=0 the response is formed on the capture edge, so use the live request.
    always_comb begin
        n_we       = state == IDLE ? bus.we : cap_we;
        n_err      = state == IDLE ? in_err : cap_err;
        n_idx      = state == IDLE ? bus.addr[IW+1:2] : cap_idx;
        resp_rdata = (n_we || n_err) ? 32'd0 : arr_rdata;
    end
    assign arr_we = state == RESP && cap_we && !cap_err;
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk_i  (clk_i),
        .we     (arr_we),
        .be     (cap_be),
        .windex (cap_idx),
        .wdata  (cap_wdata),
        .rindex (n_idx),
        .rdata  (arr_rdata)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            case (state)
                IDLE: if (bus.req) begin
                    cap_we    <= bus.we;
                    cap_err   <= in_err;
                    cap_idx   <= bus.addr[IW+1:2];
                    cap_wdata <= bus.wdata;
                    cap_be    <= bus.be;
                    if (LATENCY == 0) begin
                        state   <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= in_err;
                        rdata_q <= resp_rdata;
                    end else begin
                        state <= WAIT;
                        cnt   <= LAT_M1;
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    state   <= RESP;
                    ack_q   <= 1'b1;
                    err_q   <= cap_err;
                    rdata_q <= resp_rdata;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = state != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=2 main instance, LATENCY=0 side instance)
module tb_dmem_responder;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dmem_responder_if #(.AW(32)) bus0 ();
    dmem_responder_if #(.AW(32)) bus1 ();
    dmem_responder #(.DEPTH(128), .LATENCY(LAT), .AW(32)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    dmem_responder #(.DEPTH(128), .LATENCY(0), .AW(32)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    typedef struct packed {logic [31:0] rd; logic er;} resp_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_er;
    } txn_t;
    resp_t exp_q[$];
    resp_t obs_q[$];
    int cmp = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus0.ack === 1'b1) obs_q.push_back({bus0.rdata, bus0.err});
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    // Drives one request on bus0, waits for its capture and ack; lat counts cycles from capture to ack.
    task automatic issue(input txn_t t, input bit hold, output int lat, output int ack_at);
        int n;
        bus0.we    = t.we;
        bus0.addr  = t.addr;
        bus0.wdata = t.wdata;
        bus0.be    = t.be;
        bus0.req   = 1'b1;
        lat = -1;
        ack_at = -1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus0.busy !== 1'b1 && n < 20);
        if (bus0.busy !== 1'b1) begin
            bus0.req = 1'b0;
            return;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus0.ack === 1'b1) begin
                lat = i;
                ack_at = cyc;
                break;
            end
        end
        if (!hold || lat < 0) bus0.req = 1'b0;
        #1;
    endtask
    task automatic test_reset();
        #12;
        cmp++; if (bus0.ack !== 1'b0) begin bad++; $display("FAIL reset ack: got %b want 0", bus0.ack); end
        cmp++; if (bus0.err !== 1'b0) begin bad++; $display("FAIL reset err: got %b want 0", bus0.err); end
        cmp++; if (bus0.rdata !== 32'd0) begin bad++; $display("FAIL reset rdata: got %h want 0", bus0.rdata); end
        cmp++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus0.busy); end
        cmp++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset busy(lat0): got %b want 0", bus1.busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask
    task automatic test_store_load();
        txn_t t[2];
        int lat, at;
        resp_t o, e;
        t[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({t[i].exp_rd, t[i].exp_er});
            issue(t[i], 1'b0, lat, at);
            cmp++; if (lat != LAT + 1) begin bad++; $display("FAIL store_load[%0d] latency: got %0d want %0d", i, lat, LAT + 1); end
            e = exp_q.pop_front();
            cmp++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL store_load[%0d] resp: got none want rdata=%h err=%b", i, e.rd, e.er); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL store_load[%0d] resp: got rdata=%h err=%b want rdata=%h err=%b", i, o.rd, o.er, e.rd, e.er); end
            end
        end
    endtask
    task automatic test_byte_enable();
        txn_t t[4];
        int lat, at;
        resp_t o, e;
        t[0] = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
        t[2] = '{1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0};
        t[3] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({t[i].exp_rd, t[i].exp_er});
            issue(t[i], 1'b0, lat, at);
            cmp++; if (lat != LAT + 1) begin bad++; $display("FAIL byte_enable[%0d] latency: got %0d want %0d", i, lat, LAT + 1); end
            e = exp_q.pop_front();
            cmp++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL byte_enable[%0d] resp: got none want rdata=%h err=%b", i, e.rd, e.er); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL byte_enable[%0d] resp: got rdata=%h err=%b want rdata=%h err=%b", i, o.rd, o.er, e.rd, e.er); end
            end
        end
    endtask
    task automatic test_errors();
        txn_t t[9];
        int lat, at;
        resp_t o, e;
        t[0] = '{1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1};
        t[2] = '{1'b0, 32'h200, 32'h0, 4'h0, 32'h0, 1'b1};
        t[3] = '{1'b1, 32'h200, 32'h12345678, 4'hF, 32'h0, 1'b1};
        t[4] = '{1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
        t[5] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0};
        t[6] = '{1'b1, 32'h1FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        t[7] = '{1'b0, 32'h1FC, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
        t[8] = '{1'b0, 32'h80000000, 32'h0, 4'h0, 32'h0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({t[i].exp_rd, t[i].exp_er});
            issue(t[i], 1'b0, lat, at);
            cmp++; if (lat != LAT + 1) begin bad++; $display("FAIL errors[%0d] latency: got %0d want %0d", i, lat, LAT + 1); end
            e = exp_q.pop_front();
            cmp++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL errors[%0d] resp: got none want rdata=%h err=%b", i, e.rd, e.er); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL errors[%0d] resp: got rdata=%h err=%b want rdata=%h err=%b", i, o.rd, o.er, e.rd, e.er); end
            end
        end
    endtask
    task automatic test_back_to_back();
        txn_t t[6];
        int lat, at, prev;
        resp_t o, e;
        t[0] = '{1'b1, 32'h0, 32'd1, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h4, 32'd2, 4'hF, 32'h0, 1'b0};
        t[2] = '{1'b1, 32'h8, 32'd3, 4'hF, 32'h0, 1'b0};
        t[3] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'd1, 1'b0};
        t[4] = '{1'b0, 32'h4, 32'h0, 4'h0, 32'd2, 1'b0};
        t[5] = '{1'b0, 32'h8, 32'h0, 4'h0, 32'd3, 1'b0};
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({t[i].exp_rd, t[i].exp_er});
            issue(t[i], i < 2, lat, at);
            cmp++; if (lat != LAT + 1) begin bad++; $display("FAIL back_to_back[%0d] latency: got %0d want %0d", i, lat, LAT + 1); end
            if (i == 1 || i == 2) begin
                cmp++; if (at - prev != LAT + 2) begin bad++; $display("FAIL back_to_back[%0d] ack spacing: got %0d want %0d", i, at - prev, LAT + 2); end
            end
            prev = at;
            e = exp_q.pop_front();
            cmp++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL back_to_back[%0d] resp: got none want rdata=%h err=%b", i, e.rd, e.er); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL back_to_back[%0d] resp: got rdata=%h err=%b want rdata=%h err=%b", i, o.rd, o.er, e.rd, e.er); end
            end
        end
    endtask
    task automatic test_reset_abort();
        txn_t t[3];
        int lat, at;
        resp_t o, e;
        t[0] = '{1'b1, 32'h20, 32'h11, 4'hF, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11, 1'b0};
        t[2] = '{1'b0, 32'h20, 32'h0, 4'h0, 32'h11, 1'b0};
        @(posedge clk);
        #1;
        bus0.we = 1'b1; bus0.addr = 32'h20; bus0.wdata = 32'h55; bus0.be = 4'hF; bus0.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        cmp++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL abort_wait busy: got %b want 0", bus0.busy); end
        cmp++; if (bus0.ack !== 1'b0) begin bad++; $display("FAIL abort_wait ack: got %b want 0", bus0.ack); end
        cmp++; if (bus0.err !== 1'b0) begin bad++; $display("FAIL abort_wait err: got %b want 0", bus0.err); end
        bus0.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        cmp++; if (obs_q.size() != 0) begin bad++; $display("FAIL abort_wait spurious acks: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                @(posedge clk);
                #1;
                bus0.we = 1'b1; bus0.addr = 32'h20; bus0.wdata = 32'h99; bus0.be = 4'hF; bus0.req = 1'b1;
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                cmp++; if (bus0.ack !== 1'b1) begin bad++; $display("FAIL abort_resp in-resp ack: got %b want 1", bus0.ack); end
                rst = 1'b1;
                #1;
                cmp++; if (bus0.ack !== 1'b0) begin bad++; $display("FAIL abort_resp ack: got %b want 0", bus0.ack); end
                cmp++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL abort_resp busy: got %b want 0", bus0.busy); end
                bus0.req = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
            end
            exp_q.push_back({t[i].exp_rd, t[i].exp_er});
            issue(t[i], 1'b0, lat, at);
            cmp++; if (lat != LAT + 1) begin bad++; $display("FAIL reset_abort[%0d] latency: got %0d want %0d", i, lat, LAT + 1); end
            e = exp_q.pop_front();
            cmp++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL reset_abort[%0d] resp: got none want rdata=%h err=%b", i, e.rd, e.er); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL reset_abort[%0d] resp: got rdata=%h err=%b want rdata=%h err=%b", i, o.rd, o.er, e.rd, e.er); end
            end
        end
    endtask
    task automatic test_latency0();
        @(posedge clk);
        #1;
        bus1.we = 1'b1; bus1.addr = 32'h4; bus1.wdata = 32'hCAFEF00D; bus1.be = 4'hF; bus1.req = 1'b1;
        @(posedge clk);
        #1;
        cmp++; if (bus1.ack !== 1'b1) begin bad++; $display("FAIL lat0 store ack: got %b want 1", bus1.ack); end
        cmp++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL lat0 store busy: got %b want 1", bus1.busy); end
        cmp++; if ({bus1.rdata, bus1.err} !== 33'h0) begin bad++; $display("FAIL lat0 store resp: got rdata=%h err=%b want rdata=0 err=0", bus1.rdata, bus1.err); end
        bus1.req = 1'b0;
        @(posedge clk);
        #1;
        cmp++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL lat0 store busy after: got %b want 0", bus1.busy); end
        bus1.we = 1'b0; bus1.req = 1'b1;
        @(posedge clk);
        #1;
        cmp++; if (bus1.ack !== 1'b1) begin bad++; $display("FAIL lat0 load ack: got %b want 1", bus1.ack); end
        cmp++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL lat0 load busy: got %b want 1", bus1.busy); end
        cmp++; if (bus1.rdata !== 32'hCAFEF00D || bus1.err !== 1'b0) begin bad++; $display("FAIL lat0 load resp: got rdata=%h err=%b want rdata=cafef00d err=0", bus1.rdata, bus1.err); end
        bus1.req = 1'b0;
        @(posedge clk);
        #1;
        cmp++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL lat0 load busy after: got %b want 0", bus1.busy); end
        cmp++; if (bus1.ack !== 1'b0) begin bad++; $display("FAIL lat0 load ack after: got %b want 0", bus1.ack); end
    endtask
    initial begin
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0; bus0.be = 4'h0;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'h0; bus1.wdata = 32'h0; bus1.be = 4'h0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_latency0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
